result_display_ctrl: RTL and testbench
======================================

# result_display_ctrl

Output stage that sits directly downstream of the CPU's 16-bit `outputWire` on the board. It captures a result on a load strobe and drives the four board seven-segment digits HEX3..HEX0. In hex mode it shows the raw value. In decimal mode it runs a sequential double-dabble binary-to-BCD conversion and shows four decimal digits, with an overflow indication when the value exceeds 9999.

## Interface
- `CONV_CYCLES`, default 16: shift iterations for the double-dabble conversion; equals the `value` width.
- `CLK` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces the reset state immediately.
- `value` in 16: result word from the CPU (`outputWire`).
- `load` in 1: capture strobe; sampled on the rising edge of `CLK`.
- `decimal` in 1: 1 selects decimal display, 0 selects hex; sampled together with `load`.
- `busy` out 1: high while a capture is being processed.
- `overflow` out 1: high while the displayed decimal value is greater than 9999.
- `HEX0`..`HEX3` out 7 each: active-low segments, bit0 = a ... bit6 = g. HEX0 is the least significant digit.

## Operation
- States: IDLE, CONVERT, UPDATE.
- IDLE:
  - On `load`=1, latch `value` and `decimal`, and set `busy`.
  - In decimal mode, clear the 20-bit BCD register, load the shift register with `value`, clear the iteration counter, and go to CONVERT.
  - In hex mode, go directly to UPDATE.
- CONVERT: each cycle, first add 3 to every BCD nibble that is ≥5, then shift {BCD, bin} left by 1. After `CONV_CYCLES` iterations (counter 0..15), go to UPDATE.
- UPDATE: register the new digits and `overflow`, clear `busy`, return to IDLE.
- Hex mode: nibble[15:12] goes to HEX3 ... nibble[3:0] to HEX0; `overflow`=0.
- Decimal mode, BCD digit 4 (ten-thousands) is nonzero: all four HEX outputs = dash 7'h3F and `overflow`=1.
- Decimal mode otherwise: BCD digits 3..0 go to HEX3..HEX0, leading zeros are shown, `overflow`=0.
- Segment codes:
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Letters: A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - Dash = 3F, blank = 7F.
- `load` while `busy` is ignored; there is no queueing. `value` may change freely after capture.
- HEX outputs and `overflow` hold their last values until the next UPDATE.

## Timing
- Reset values: HEX0..HEX3 = 7'h7F (blank), `busy`=0, `overflow`=0, state IDLE, counter 0.
- Hex mode:
  - `load` sampled at edge k.
  - `busy` is 1 after edge k and 0 after edge k+1.
  - HEX outputs are valid after edge k+1.
- Decimal mode:
  - `load` sampled at edge k.
  - CONVERT occupies edges k+1..k+16.
  - UPDATE at edge k+17: HEX outputs and `overflow` are valid and `busy` falls.
  - `busy` is high for exactly 17 cycles.
- The earliest next accepted `load` is the edge after `busy` falls (edge k+2 in hex mode, k+18 in decimal mode).
- Reset asserted mid-CONVERT: outputs go blank asynchronously and the partial conversion is discarded. Operation resumes with the first `load` sampled after reset deasserts.
- `load` and `reset` asserted together: reset wins.
- All outputs are registered; nothing combinational reaches the HEX pins.

## Structure
- Shared package:
  - Segment constants (SEG_0..SEG_F, SEG_DASH, SEG_BLANK).
  - State enum {IDLE, CONVERT, UPDATE}.
  - `DISPLAY_DIGITS`=4 and the 9999 overflow limit.
- Sub-module `seg7_decode`: combinational 4-bit nibble to 7-bit active-low segments, instantiated four times.
- Overflow and dash substitution live in the top block, not in `seg7_decode`.
- Expected RTL size: about 200 lines total.

## Test plan
- Reset, then no load → HEX0..3 = 7F, `busy`=0, `overflow`=0.
- Hex mode, `value`=16'h1A2F, one `load` pulse → after 1 more edge: HEX3=79, HEX2=08, HEX1=24, HEX0=0E; `busy` high 1 cycle.
- Decimal mode, `value`=1234 → after 17 edges: HEX3=79, HEX2=24, HEX1=30, HEX0=19; `busy` high 17 cycles. Also `value`=0 → all four digits 40.
- Decimal mode, `value`=9999 → all digits 10, `overflow`=0. Then `value`=10000 → all digits 3F, `overflow`=1. Then `value`=65535 → all digits 3F, `overflow`=1.
- `load` with `value`=5 in decimal mode, second `load` with `value`=7 at cycle 5 of busy → display shows 0005 (40,40,40,12); the second load is ignored.
- Reset pulse at cycle 8 of a decimal conversion of 4321 → blank immediately, `busy`=0. A subsequent load of 42 displays 40,40,19,24.

Source files
------------

// File: rtl/result_display_ctrl_pkg.sv
// Shared definitions for the result display stage: segment codes, the
// controller states and a double-dabble helper.
package result_display_ctrl_pkg;

  localparam int DISPLAY_DIGITS = 4;
  localparam int OVF_LIMIT      = 9999;

  // Active-low segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_t;

  // Pre-shift correction: any BCD digit >= 5 would exceed 9 after doubling.
  function automatic logic [19:0] bcd_add3(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/result_display_ctrl_if.sv
// Result/display bundle between the CPU output wire, the display controller
// and the four seven-segment digits.
interface result_display_ctrl_if;
  logic [15:0] value;
  logic        load;
  logic        decimal;
  logic        busy;
  logic        overflow;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;

  modport master (
    output value, load, decimal,
    input  busy, overflow, HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  value, load, decimal,
    output busy, overflow, HEX0, HEX1, HEX2, HEX3
  );
endinterface

// File: rtl/result_display_ctrl_seg7_decode.sv
// Combinational nibble to active-low seven-segment pattern (0-9, A-F).
module seg7_decode
  import result_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display_ctrl.sv
// Captures a CPU result and shows it on HEX3..HEX0, either raw hex or as
// four decimal digits via a sequential double-dabble conversion.
module result_display_ctrl
  import result_display_ctrl_pkg::*;
#(
  parameter int CONV_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 reset,
  result_display_ctrl_if.slave bus
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

  state_t                               state_q, state_d;
  logic [15:0]                          bin_q, bin_d;
  logic [19:0]                          bcd_q, bcd_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic                                 dec_q, dec_d;
  logic                                 busy_q, busy_d;
  logic                                 ovf_q, ovf_d;
  logic [DISPLAY_DIGITS-1:0][6:0]       hex_q, hex_d;

  logic [15:0]                          disp_src;
  logic [DISPLAY_DIGITS-1:0][6:0]       seg;
  logic [35:0]                          shifted;

  // In hex mode bin_q keeps the raw captured value untouched.
  assign disp_src = dec_q ? bcd_q[15:0] : bin_q;
  assign shifted  = {bcd_add3(bcd_q), bin_q} << 1;

  genvar gi;
  generate
    for (gi = 0; gi < DISPLAY_DIGITS; gi++) begin : g_dec
      seg7_decode u_dec (
        .nibble (disp_src[gi*4 +: 4]),
        .seg    (seg[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      hex_q   <= {DISPLAY_DIGITS{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          bin_d  = bus.value;
          dec_d  = bus.decimal;
          busy_d = 1'b1;
          if (bus.decimal) begin
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = CONVERT;
          end else begin
            state_d = UPDATE;
          end
        end
      end
      CONVERT: begin
        {bcd_d, bin_d} = shifted;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        // A nonzero ten-thousands digit means the value cannot fit in four digits.
        if (dec_q && (bcd_q[19:16] != 4'd0)) begin
          hex_d = {DISPLAY_DIGITS{SEG_DASH}};
          ovf_d = 1'b1;
        end else begin
          hex_d = seg;
          ovf_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;
  assign bus.HEX0     = hex_q[0];
  assign bus.HEX1     = hex_q[1];
  assign bus.HEX2     = hex_q[2];
  assign bus.HEX3     = hex_q[3];

endmodule

// File: tb/tb_result_display_ctrl.sv
// Self-checking bench for result_display_ctrl: directed cases plus random
// captures compared against an arithmetic model of the display.
module tb_result_display_ctrl;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  result_display_ctrl_if bus ();

  result_display_ctrl #(.CONV_CYCLES(16)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [6:0] hex_obs [4];
  assign hex_obs[0] = bus.HEX0;
  assign hex_obs[1] = bus.HEX1;
  assign hex_obs[2] = bus.HEX2;
  assign hex_obs[3] = bus.HEX3;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] model_digit(input int v, input bit dec, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (!dec) return seg_of((v >> (4 * i)) & 15);
    if (v > 9999) return 7'h3F;
    return seg_of((v / p) % 10);
  endfunction

  task automatic do_load(input logic [15:0] v, input logic dec, output int busy_cycles);
    @(negedge CLK);
    bus.value = v; bus.decimal = dec; bus.load = 1'b1;
    @(negedge CLK);
    bus.load = 1'b0; bus.value = 16'($urandom); bus.decimal = 1'($urandom);
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hex_obs[i] !== 7'h7F) begin
        n_fail++; $display("FAIL reset_hex%0d got=%h exp=7f", i, hex_obs[i]);
      end
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got busy=%b ovf=%b exp 0/0", bus.busy, bus.overflow);
    end
    $display("test_reset: blank display checked");
  endtask

  task automatic test_hex();
    int bc;
    logic [6:0] exp_h [4];
    exp_h = '{7'h0E, 7'h24, 7'h08, 7'h79};
    do_load(16'h1A2F, 1'b0, bc);
    n_cmp++;
    if (bc !== 1) begin n_fail++; $display("FAIL hex_busy got=%0d exp=1", bc); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hex_obs[i] !== exp_h[i]) begin
        n_fail++; $display("FAIL hex_hex%0d got=%h exp=%h", i, hex_obs[i], exp_h[i]);
      end
    end
    n_cmp++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL hex_ovf got=%b exp=0", bus.overflow); end
    $display("test_hex: value=1a2f busy=%0d", bc);
  endtask

  task automatic test_decimal();
    int bc;
    logic [6:0] exp_d [4];
    exp_d = '{7'h19, 7'h30, 7'h24, 7'h79};
    do_load(16'd1234, 1'b1, bc);
    n_cmp++;
    if (bc !== 17) begin n_fail++; $display("FAIL dec_busy got=%0d exp=17", bc); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hex_obs[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL dec1234_hex%0d got=%h exp=%h", i, hex_obs[i], exp_d[i]);
      end
    end
    $display("test_decimal: value=1234 busy=%0d", bc);
    do_load(16'd0, 1'b1, bc);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hex_obs[i] !== 7'h40) begin
        n_fail++; $display("FAIL dec0_hex%0d got=%h exp=40", i, hex_obs[i]);
      end
    end
    $display("test_decimal: value=0 busy=%0d", bc);
  endtask

  task automatic test_overflow();
    int bc;
    int vals [3];
    logic [6:0] exp_seg [3];
    logic exp_ovf [3];
    vals = '{9999, 10000, 65535};
    exp_seg = '{7'h10, 7'h3F, 7'h3F};
    exp_ovf = '{1'b0, 1'b1, 1'b1};
    for (int t = 0; t < 3; t++) begin
      do_load(16'(vals[t]), 1'b1, bc);
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (hex_obs[i] !== exp_seg[t]) begin
          n_fail++; $display("FAIL ovf%0d_hex%0d got=%h exp=%h", vals[t], i, hex_obs[i], exp_seg[t]);
        end
      end
      n_cmp++;
      if (bus.overflow !== exp_ovf[t]) begin
        n_fail++; $display("FAIL ovf%0d_flag got=%b exp=%b", vals[t], bus.overflow, exp_ovf[t]);
      end
      $display("test_overflow: value=%0d ovf=%b", vals[t], bus.overflow);
    end
  endtask

  task automatic test_load_ignored();
    int bc;
    logic [6:0] exp_d [4];
    exp_d = '{7'h12, 7'h40, 7'h40, 7'h40};
    @(negedge CLK);
    bus.value = 16'd5; bus.decimal = 1'b1; bus.load = 1'b1;
    @(negedge CLK);
    bus.load = 1'b0;
    bc = 0;
    while (bus.busy && bc < 100) begin
      bc++;
      if (bc == 5) begin bus.value = 16'd7; bus.load = 1'b1; end
      else bus.load = 1'b0;
      @(negedge CLK);
    end
    bus.load = 1'b0;
    n_cmp++;
    if (bc !== 17) begin n_fail++; $display("FAIL ign_busy got=%0d exp=17", bc); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hex_obs[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL ign_hex%0d got=%h exp=%h", i, hex_obs[i], exp_d[i]);
      end
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue busy=%b exp=0", bus.busy); end
    $display("test_load_ignored: value=5 then 7 during busy");
  endtask

  task automatic test_reset_mid();
    int bc;
    logic [6:0] exp_d [4];
    exp_d = '{7'h24, 7'h19, 7'h40, 7'h40};
    @(negedge CLK);
    bus.value = 16'd4321; bus.decimal = 1'b1; bus.load = 1'b1;
    @(negedge CLK);
    bus.load = 1'b0;
    repeat (7) @(negedge CLK);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hex_obs[i] !== 7'h7F) begin
        n_fail++; $display("FAIL rstmid_hex%0d got=%h exp=7f", i, hex_obs[i]);
      end
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    @(negedge CLK);
    bus.value = 16'd9; bus.decimal = 1'b0; bus.load = 1'b1;
    @(negedge CLK);
    reset = 1'b0; bus.load = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (bus.busy !== 1'b0 || hex_obs[0] !== 7'h7F) begin
      n_fail++; $display("FAIL rst_wins got busy=%b hex0=%h exp 0/7f", bus.busy, hex_obs[0]);
    end
    do_load(16'd42, 1'b1, bc);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hex_obs[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL post_rst_hex%0d got=%h exp=%h", i, hex_obs[i], exp_d[i]);
      end
    end
    $display("test_reset_mid: reset during 4321, then 42 busy=%0d", bc);
  endtask

  task automatic test_random();
    int bc;
    int v;
    bit dec;
    logic [6:0] e;
    for (int t = 0; t < 24; t++) begin
      v = (t % 3 == 0) ? int'($urandom_range(9000, 11000)) : int'($urandom_range(0, 65535));
      dec = 1'($urandom);
      do_load(16'(v), dec, bc);
      n_cmp++;
      if (bc !== (dec ? 17 : 1)) begin
        n_fail++; $display("FAIL rnd_busy v=%0d dec=%b got=%0d exp=%0d", v, dec, bc, dec ? 17 : 1);
      end
      for (int i = 0; i < 4; i++) begin
        e = model_digit(v, dec, i);
        n_cmp++;
        if (hex_obs[i] !== e) begin
          n_fail++; $display("FAIL rnd_hex%0d v=%0d dec=%b got=%h exp=%h", i, v, dec, hex_obs[i], e);
        end
      end
      n_cmp++;
      if (bus.overflow !== (dec && v > 9999)) begin
        n_fail++; $display("FAIL rnd_ovf v=%0d dec=%b got=%b exp=%b", v, dec, bus.overflow, dec && v > 9999);
      end
      $display("test_random: v=%0d dec=%b busy=%0d", v, dec, bc);
    end
  endtask

  initial begin
    bus.value = '0; bus.load = 1'b0; bus.decimal = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_load_ignored();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
